// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell and a borrow flop,
// iterated LSB-first over shift registers, with a Start/Busy/Done handshake.
// Difference = (A - B - Borrow_in) mod 2^WIDTH. Borrow_out and Overflow are
// the unsigned and signed out-of-range flags. All outputs are registered.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Borrow_in,
  output logic [WIDTH-1:0] Difference,
  output logic             Borrow_out,
  output logic             Overflow,
  output logic             Busy,
  output logic             Done
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-1:0]   d_sr;
  logic               borrow;
  logic [CNT_W-1:0]   cnt;

  // Full-subtractor cell working on the current LSBs of the operand registers.
  logic a_bit;
  logic b_bit;
  logic d_bit;
  logic borrow_next;
  logic last_bit;

  assign a_bit       = a_sr[0];
  assign b_bit       = b_sr[0];
  assign d_bit       = a_bit ^ b_bit ^ borrow;
  assign borrow_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow);
  assign last_bit    = (cnt == CNT_W'(WIDTH - 1));

  // Handshake FSM, serial datapath and registered result outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      d_sr       <= '0;
      borrow     <= 1'b0;
      cnt        <= '0;
      Difference <= '0;
      Borrow_out <= 1'b0;
      Overflow   <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
    end else begin
      // NOTE: every register here uses non-blocking assignment so all of them
      // see the pre-edge values of a_sr/b_sr/borrow, exactly like real flops.
      case (state)
        IDLE: begin
          if (Start) begin
            a_sr   <= A;
            b_sr   <= B;
            borrow <= Borrow_in;
            cnt    <= '0;
            Busy   <= 1'b1;
            state  <= SHIFT;
          end
        end

        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          d_sr   <= {d_bit, d_sr[WIDTH-1:1]};
          borrow <= borrow_next;
          cnt    <= cnt + 1'b1;
          if (last_bit) begin
            // At the last bit a_bit/b_bit are the operand MSBs, d_bit the result MSB.
            Difference <= {d_bit, d_sr[WIDTH-1:1]};
            Borrow_out <= borrow_next;
            Overflow   <= (a_bit ^ b_bit) & (d_bit ^ a_bit);
            Done       <= 1'b1;
            state      <= DONE;
          end
        end

        DONE: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: an 8-bit instance for the main
// vectors and handshake corner cases, and a 2-bit instance for the
// full-subtractor truth table.
module tb_serial_subtractor;

  logic       clk;
  logic       rst;

  logic       start8, bin8;
  logic [7:0] a8, b8, diff8;
  logic       bo8, ov8, busy8, done8;

  logic       start2, bin2;
  logic [1:0] a2, b2, diff2;
  logic       bo2, ov2, busy2, done2;

  int checks   = 0;
  int failures = 0;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .Clock(clk), .Reset(rst), .Start(start8), .A(a8), .B(b8), .Borrow_in(bin8),
    .Difference(diff8), .Borrow_out(bo8), .Overflow(ov8), .Busy(busy8), .Done(done8)
  );

  serial_subtractor #(.WIDTH(2)) dut2 (
    .Clock(clk), .Reset(rst), .Start(start2), .A(a2), .B(b2), .Borrow_in(bin2),
    .Difference(diff2), .Borrow_out(bo2), .Overflow(ov2), .Busy(busy2), .Done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } vec_t;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Launch one operation on the selected instance; returns the number of
  // cycles from Busy rising until Done is seen (bounded).
  task automatic run_op(input bit w2, input logic [7:0] a, input logic [7:0] b,
                        input logic bin, output int cyc);
    @(negedge clk);
    if (w2) begin
      a2 = a[1:0]; b2 = b[1:0]; bin2 = bin; start2 = 1'b1;
    end else begin
      a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
    end
    @(negedge clk);
    start2 = 1'b0;
    start8 = 1'b0;
    cyc = 0;
    while (!(w2 ? done2 : done8) && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  vec_t v8[7];
  vec_t v2[8];
  int   cyc;
  int   done_cnt;
  int   since;
  int   k;
  bit   stable;
  logic [7:0] ga[3];
  logic [7:0] gb[3];
  logic       gbin[3];
  logic [7:0] gold;

  initial begin
    v8[0] = '{8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0};
    v8[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    v8[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    v8[3] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0};
    v8[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    v8[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    v8[6] = '{8'hC8, 8'h64, 1'b1, 8'h63, 1'b0, 1'b1};

    // {a0,b0,bin} truth table; Difference = {borrow, diff bit} for 1-bit operands
    v2[0] = '{8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0};
    v2[1] = '{8'd0, 8'd0, 1'b1, 8'd3, 1'b1, 1'b0};
    v2[2] = '{8'd0, 8'd1, 1'b0, 8'd3, 1'b1, 1'b0};
    v2[3] = '{8'd0, 8'd1, 1'b1, 8'd2, 1'b1, 1'b0};
    v2[4] = '{8'd1, 8'd0, 1'b0, 8'd1, 1'b0, 1'b0};
    v2[5] = '{8'd1, 8'd0, 1'b1, 8'd0, 1'b0, 1'b0};
    v2[6] = '{8'd1, 8'd1, 1'b0, 8'd0, 1'b0, 1'b0};
    v2[7] = '{8'd1, 8'd1, 1'b1, 8'd3, 1'b1, 1'b0};

    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; bin2 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("reset_outputs8", {diff8, bo8, ov8, busy8, done8}, '0);
    check("reset_outputs2", {diff2, bo2, ov2, busy2, done2}, '0);

    // 8-bit vectors, including the boundary cases
    for (int i = 0; i < 7; i++) begin
      run_op(1'b0, v8[i].a, v8[i].b, v8[i].bin, cyc);
      check($sformatf("latency8_%0d", i), cyc, 8);
      check($sformatf("diff8_%0d", i), diff8, v8[i].d);
      check($sformatf("borrow8_%0d", i), bo8, v8[i].bo);
      check($sformatf("ovf8_%0d", i), ov8, v8[i].ov);
      check($sformatf("busy_in_done8_%0d", i), busy8, 1'b1);
      @(negedge clk);
      check($sformatf("idle_after8_%0d", i), {busy8, done8}, 2'b00);
      check($sformatf("hold_diff8_%0d", i), diff8, v8[i].d);
    end

    // 2-bit truth table
    for (int i = 0; i < 8; i++) begin
      run_op(1'b1, v2[i].a, v2[i].b, v2[i].bin, cyc);
      check($sformatf("latency2_%0d", i), cyc, 2);
      check($sformatf("diff2_%0d", i), diff2, v2[i].d[1:0]);
      check($sformatf("borrow2_%0d", i), bo2, v2[i].bo);
      check($sformatf("ovf2_%0d", i), ov2, v2[i].ov);
      @(negedge clk);
    end

    // Start pulses during SHIFT and DONE are ignored
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h23; bin8 = 1'b0; start8 = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done8) done_cnt++;
      if (i == 3 || i == 8) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
    end
    start8 = 1'b0;
    check("ignored_start_done_count", done_cnt, 1);
    check("ignored_start_diff", diff8, 8'h37);
    check("ignored_start_idle", busy8, 1'b0);

    // Reset in the middle of SHIFT discards the operation
    @(negedge clk);
    a8 = 8'hF0; b8 = 8'h0F; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midshift_reset_outputs", {diff8, bo8, ov8, busy8, done8}, '0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("midshift_reset_stays_idle", {diff8, busy8, done8}, '0);
    run_op(1'b0, 8'h80, 8'h01, 1'b0, cyc);
    check("after_reset_latency", cyc, 8);
    check("after_reset_diff", diff8, 8'h7F);
    check("after_reset_ovf", ov8, 1'b1);
    @(negedge clk);

    // Start held high: back-to-back operations every WIDTH+2 cycles
    ga[0] = 8'h33; gb[0] = 8'h44; gbin[0] = 1'b0;
    ga[1] = 8'hA5; gb[1] = 8'h5A; gbin[1] = 1'b1;
    ga[2] = 8'h01; gb[2] = 8'h01; gbin[2] = 1'b0;
    @(negedge clk);
    a8 = ga[0]; b8 = gb[0]; bin8 = gbin[0]; start8 = 1'b1;
    k = 0; since = 0; stable = 1'b1; gold = '0;
    for (int i = 0; i < 60 && k < 3; i++) begin
      @(negedge clk);
      since++;
      if (done8) begin
        gold = ga[k] - gb[k] - {7'd0, gbin[k]};
        check($sformatf("b2b_diff_%0d", k), diff8, gold);
        if (k > 0) check($sformatf("b2b_period_%0d", k), since, 10);
        since = 0;
        k++;
        if (k < 3) begin
          a8 = ga[k]; b8 = gb[k]; bin8 = gbin[k];
        end
      end else if (k > 0 && diff8 !== gold) begin
        stable = 1'b0;
      end
    end
    start8 = 1'b0;
    check("b2b_done_count", k, 3);
    check("b2b_diff_stable", stable, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
